// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and default geometry for the icache controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int ADDR_WIDTH_DEF         = 32;
    localparam int INDEX_LENGTH_DEF       = 4;
    localparam int WORD_OFFSET_LENGTH_DEF = 4;
    localparam int DATA_WIDTH_DEF         = 32;
    localparam int TAG_LENGTH_DEF         = ADDR_WIDTH_DEF - INDEX_LENGTH_DEF
                                            - WORD_OFFSET_LENGTH_DEF - 2;

    localparam int CACHE_LINES    = 2 ** INDEX_LENGTH_DEF;
    localparam int WORDS_PER_LINE = 2 ** WORD_OFFSET_LENGTH_DEF;

    // Byte address layout: {tag, index, word offset, byte offset}
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + WORD_OFFSET_LENGTH_DEF;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_LENGTH_DEF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_REFILL = 2'd2,
        S_RESP   = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/valid_array.sv
// ============================================================================
// Module      : valid_array
// Description : Per-line valid bits: set-by-index, clear-all, comb read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module valid_array #(
    parameter int INDEX_LENGTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_i,
    input  logic [INDEX_LENGTH-1:0] set_idx_i,
    input  logic                    clr_all_i,
    input  logic [INDEX_LENGTH-1:0] rd_idx_i,
    output logic                    rd_valid_o
);

    localparam int LINES = 2 ** INDEX_LENGTH;

    logic [LINES-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_all_i) begin
            valid_q <= '0;
        end else if (set_i) begin
            valid_q[set_idx_i] <= 1'b1;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/icache_ctrl.sv
// ============================================================================
// Module      : icache_ctrl
// Description : Direct-mapped read-only cache controller with word-wise refill.
//               Optional hit/miss statistics built when CACHE_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH         = ADDR_WIDTH_DEF,
    parameter int INDEX_LENGTH       = INDEX_LENGTH_DEF,
    parameter int WORD_OFFSET_LENGTH = WORD_OFFSET_LENGTH_DEF,
    parameter int TAG_LENGTH         = ADDR_WIDTH - INDEX_LENGTH - WORD_OFFSET_LENGTH - 2,
    parameter int DATA_WIDTH         = DATA_WIDTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req_valid_i,
    output logic                                     req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                    req_addr_i,
    output logic                                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]                    resp_data_o,
    input  logic                                     flush_i,
    output logic [INDEX_LENGTH-1:0]                  index_o,
    output logic [TAG_LENGTH-1:0]                    tag_o,
    output logic                                     tag_we_o,
    input  logic [TAG_LENGTH-1:0]                    tag_rd_i,
    output logic [INDEX_LENGTH+WORD_OFFSET_LENGTH-1:0] data_addr_o,
    output logic                                     data_we_o,
    output logic [DATA_WIDTH-1:0]                    data_wdata_o,
    input  logic [DATA_WIDTH-1:0]                    data_rdata_i,
    output logic                                     mem_req_o,
    output logic [ADDR_WIDTH-1:0]                    mem_addr_o,
    input  logic                                     mem_ack_i,
    input  logic [DATA_WIDTH-1:0]                    mem_data_i,
    output logic [31:0]                              hit_cnt_o,
    output logic [31:0]                              miss_cnt_o
);

    localparam int IDX_LSB = 2 + WORD_OFFSET_LENGTH;
    localparam int TG_LSB  = IDX_LSB + INDEX_LENGTH;

    state_e                          state_q, state_d;
    logic [TAG_LENGTH-1:0]           tag_q, tag_d;
    logic [INDEX_LENGTH-1:0]         idx_q, idx_d;
    logic [WORD_OFFSET_LENGTH-1:0]   off_q, off_d;
    logic [WORD_OFFSET_LENGTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;

    logic w_line_valid;
    logic w_hit;
    logic w_valid_set;
    logic w_valid_clr;
    logic w_unused;

    assign w_unused = ^req_addr_i[1:0];

    valid_array #(
        .INDEX_LENGTH (INDEX_LENGTH)
    ) u_valid_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (w_valid_set),
        .set_idx_i  (idx_q),
        .clr_all_i  (w_valid_clr),
        .rd_idx_i   (idx_q),
        .rd_valid_o (w_line_valid)
    );

    assign w_hit       = w_line_valid && (tag_rd_i == tag_q);
    assign index_o     = idx_q;
    assign tag_o       = tag_q;
    assign resp_data_o = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        tag_we_o     = 1'b0;
        data_addr_o  = {idx_q, off_q};
        data_we_o    = 1'b0;
        data_wdata_o = '0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        w_valid_set  = 1'b0;
        w_valid_clr  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = rst_n && !flush_i;
                if (flush_i) begin
                    w_valid_clr = 1'b1;
                end else if (req_valid_i) begin
                    tag_d   = req_addr_i[TG_LSB +: TAG_LENGTH];
                    idx_d   = req_addr_i[IDX_LSB +: INDEX_LENGTH];
                    off_d   = req_addr_i[2 +: WORD_OFFSET_LENGTH];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    rdata_d = data_rdata_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag_q, idx_q, cnt_q, 2'b00};
                data_addr_o = {idx_q, cnt_q};
                if (mem_ack_i) begin
                    data_we_o    = 1'b1;
                    data_wdata_o = mem_data_i;
                    cnt_d        = cnt_q + 1'b1;
                    // Last word: publish the tag and mark the line usable.
                    if (&cnt_q) begin
                        tag_we_o    = 1'b1;
                        w_valid_set = 1'b1;
                        state_d     = S_LOOKUP;
                    end
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        refilled_q;

    // LOOKUP is entered from IDLE or REFILL only; the post-refill lookup is not a request hit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            refilled_q <= 1'b0;
        end else begin
            refilled_q <= (state_q == S_REFILL);
            if (state_q == S_LOOKUP) begin
                if (w_hit) begin
                    if (!refilled_q && !(&hit_cnt_q)) begin
                        hit_cnt_q <= hit_cnt_q + 32'd1;
                    end
                end else if (!(&miss_cnt_q)) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// ============================================================================
// Module      : tb_icache_ctrl
// Description : Scoreboard bench for icache_ctrl with tag/data RAM and memory models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_ctrl;

    localparam int AW = 32;
    localparam int IL = 4;
    localparam int WL = 4;
    localparam int TL = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i;
    logic            resp_valid_o;
    logic [DW-1:0]   resp_data_o;
    logic            flush_i;
    logic [IL-1:0]   index_o;
    logic [TL-1:0]   tag_o;
    logic            tag_we_o;
    logic [TL-1:0]   tag_rd_i;
    logic [IL+WL-1:0] data_addr_o;
    logic            data_we_o;
    logic [DW-1:0]   data_wdata_o;
    logic [DW-1:0]   data_rdata_i;
    logic            mem_req_o;
    logic [AW-1:0]   mem_addr_o;
    logic            mem_ack_i;
    logic [DW-1:0]   mem_data_i;
    logic [31:0]     hit_cnt_o;
    logic [31:0]     miss_cnt_o;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .flush_i      (flush_i),
        .index_o      (index_o),
        .tag_o        (tag_o),
        .tag_we_o     (tag_we_o),
        .tag_rd_i     (tag_rd_i),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_wdata_o (data_wdata_o),
        .data_rdata_i (data_rdata_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    // External tag and data RAMs: synchronous write, combinational read
    logic [TL-1:0] tag_ram  [16];
    logic [DW-1:0] data_ram [256];
    always @(posedge clk) begin
        if (tag_we_o)  tag_ram[index_o]      <= tag_o;
        if (data_we_o) data_ram[data_addr_o] <= data_wdata_o;
    end
    assign tag_rd_i     = tag_ram[index_o];
    assign data_rdata_i = data_ram[data_addr_o];

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    typedef struct {
        logic [31:0] data;
        bit          hit;
        longint      acc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] addr_q[$];
    logic [25:0] tagw_q[$];
    bit          mvalid[16];
    logic [21:0] mtag[16];
    int          m_hits, m_misses;

    int     n_cmp = 0;
    int     n_fail = 0;
    longint cyc = 0;
    int     resp_cnt = 0;
    int     total_acks = 0;
    int     abort_target = -1;
    int     wait_left = 0;
    bit     rand_wait = 1'b0;
    bit     dead = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    // Reference: a line holds the tag last fetched into it until flushed or reset
    task automatic model_access(input logic [31:0] a, input longint acc);
        logic [21:0] t;
        logic [3:0]  ix;
        bit          h;
        exp_t        e;
        t  = a[31:10];
        ix = a[9:6];
        h  = mvalid[ix] && (mtag[ix] == t);
        if (h) begin
            m_hits++;
        end else begin
            m_misses++;
            for (int w = 0; w < 16; w++) addr_q.push_back({a[31:6], 6'(w * 4)});
            tagw_q.push_back({ix, t});
            mvalid[ix] = 1'b1;
            mtag[ix]   = t;
        end
        e.data = memf(a);
        e.hit  = h;
        e.acc  = acc;
        sb_q.push_back(e);
    endtask

    // Memory responder
    always @(negedge clk) begin
        mem_ack_i  = 1'b0;
        mem_data_i = $urandom;
        if (rst_n && mem_req_o) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                if (addr_q.size() == 0) flag("unexpected_mem_req");
                else check("mem_addr", mem_addr_o, addr_q.pop_front());
                mem_ack_i  = 1'b1;
                mem_data_i = memf(mem_addr_o);
                total_acks++;
                if (total_acks == abort_target) rst_n = 1'b0;
                wait_left = rand_wait ? int'($urandom_range(0, 2)) : 0;
            end
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (resp_valid_o) begin
                if (sb_q.size() == 0) begin
                    flag("unexpected_resp");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_data", resp_data_o, e.data);
                    if (e.hit) check("hit_latency", 64'(cyc - e.acc), 64'd2);
                    else       check("miss_latency_min", 64'(cyc - e.acc >= 19), 64'd1);
                end
                resp_cnt++;
            end
            if (tag_we_o) begin
                check("tag_we_in_ack", {63'd0, mem_ack_i & mem_req_o}, 64'd1);
                if (tagw_q.size() == 0) flag("unexpected_tag_we");
                else check("tag_write", {index_o, tag_o}, tagw_q.pop_front());
            end
            if (data_we_o) begin
                check("data_we_in_ack", {63'd0, mem_ack_i & mem_req_o}, 64'd1);
                check("data_addr", data_addr_o, mem_addr_o[9:2]);
                check("data_wdata", data_wdata_o, mem_data_i);
            end
        end
    end

    task automatic send_read(input logic [31:0] a);
        int n;
        n = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        #1;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready_o) begin
            flag("req_ready_timeout");
            dead        = 1'b1;
            req_valid_i = 1'b0;
        end else begin
            model_access(a, cyc);
            @(posedge clk);
            #1;
            req_valid_i = 1'b0;
        end
    endtask

    task automatic issue_read(input logic [31:0] a);
        int tgt;
        int n;
        if (!dead) begin
            tgt = resp_cnt + 1;
            send_read(a);
            n = 0;
            while (!dead && resp_cnt < tgt && n < 400) begin
                @(negedge clk);
                #3;
                n++;
            end
            if (!dead && resp_cnt < tgt) begin
                flag("resp_timeout");
                dead = 1'b1;
            end
        end
    endtask

    task automatic flush_idle();
        @(negedge clk);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = $urandom;
        #1;
        check("ready_during_flush", {63'd0, req_ready_o}, 64'd0);
        @(negedge clk);
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        model_clear();
    endtask

    task automatic check_stats(input string tagname);
`ifdef CACHE_STATS_EN
        check({tagname, "_hit_cnt"},  hit_cnt_o,  m_hits);
        check({tagname, "_miss_cnt"}, miss_cnt_o, m_misses);
`else
        check({tagname, "_hit_cnt"},  hit_cnt_o,  64'd0);
        check({tagname, "_miss_cnt"}, miss_cnt_o, 64'd0);
`endif
    endtask

    task automatic check_idle_outputs(input string tagname);
        check({tagname, "_ready"},      {63'd0, req_ready_o},  64'd1);
        check({tagname, "_resp_valid"}, {63'd0, resp_valid_o}, 64'd0);
        check({tagname, "_mem_req"},    {63'd0, mem_req_o},    64'd0);
        check({tagname, "_mem_addr"},   mem_addr_o,            64'd0);
        check({tagname, "_tag_we"},     {63'd0, tag_we_o},     64'd0);
        check({tagname, "_data_we"},    {63'd0, data_we_o},    64'd0);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        for (int i = 0; i < 16; i++)  tag_ram[i]  = '0;
        for (int i = 0; i < 256; i++) data_ram[i] = '0;
        model_clear();
        m_hits      = 0;
        m_misses    = 0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        flush_i     = 1'b0;
        mem_ack_i   = 1'b0;
        mem_data_i  = '0;

        repeat (3) @(negedge clk);
        #1;
        check("ready_in_reset", {63'd0, req_ready_o}, 64'd0);
        rst_n = 1'b1;
        #1;
        check_idle_outputs("reset");
        check("reset_resp_data", resp_data_o, 64'd0);
        check_stats("reset");

        // Directed plan with zero-wait memory
        issue_read(32'h0000_1040);
        issue_read(32'h0000_1044);
        issue_read(32'h0000_5040);
        issue_read(32'h0000_1040);
        flush_idle();
        issue_read(32'h0000_1044);
`ifdef CACHE_STATS_EN
        check("plan_hit_cnt",  hit_cnt_o,  64'd1);
        check("plan_miss_cnt", miss_cnt_o, 64'd4);
`else
        check("plan_hit_cnt",  hit_cnt_o,  64'd0);
        check("plan_miss_cnt", miss_cnt_o, 64'd0);
`endif

        // flush_i while refilling must be ignored
        fork
            issue_read(32'h0000_2080);
            begin
                n = 0;
                while (!mem_req_o && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end
        join
        issue_read(32'h0000_2084);
        check_stats("after_refill_flush");

        // Reset on the 8th refill ack
        if (!dead) begin
            abort_target = total_acks + 8;
            send_read(32'h0000_0200);
            n = 0;
            while (rst_n && n < 400) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (rst_n) begin
                flag("abort_reset_not_reached");
                dead = 1'b1;
            end else begin
                @(posedge clk);
                @(negedge clk);
                #1;
                check("abort_mem_req", {63'd0, mem_req_o}, 64'd0);
                check("abort_ready_in_reset", {63'd0, req_ready_o}, 64'd0);
                sb_q.delete();
                addr_q.delete();
                tagw_q.delete();
                model_clear();
                m_hits       = 0;
                m_misses     = 0;
                abort_target = -1;
                wait_left    = 0;
                rst_n        = 1'b1;
                #1;
                check_idle_outputs("post_abort");
                check_stats("post_abort");
            end
        end
        issue_read(32'h0000_0200);
        issue_read(32'h0000_0204);

        // Randomized traffic with variable memory latency
        rand_wait = 1'b1;
        for (int k = 0; k < 120 && !dead; k++) begin
            if ($urandom_range(0, 15) == 0) flush_idle();
            a = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            issue_read(a);
        end
        repeat (3) @(negedge clk);
        #1;
        check_stats("final");
        check("sb_drained",    64'(sb_q.size()),   64'd0);
        check("addr_drained",  64'(addr_q.size()), 64'd0);
        check("tagw_drained",  64'(tagw_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
